// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU arbiter: opcode encoding, FSM states
// and default widths.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 2;

    typedef enum logic [OP_W_DEF-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels and the response channel of the ALU
// arbiter. master = requesters/consumer side, slave = arbiter side.
// Optional flag signals exist only when ALU_ARB_FLAGS_EN is defined.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 2
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
`ifdef ALU_ARB_FLAGS_EN
    logic              rsp_zero;
    logic              rsp_carry;
`endif

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, busy
`ifdef ALU_ARB_FLAGS_EN
        , input rsp_zero, rsp_carry
`endif
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, busy
`ifdef ALU_ARB_FLAGS_EN
        , output rsp_zero, rsp_carry
`endif
    );
endinterface

// File: rtl/alu_core.sv
// Shared combinational ALU: add/sub wrap modulo 2^DATA_W, and/or bitwise.
// With ALU_ARB_FLAGS_EN, carry_o is add carry-out or sub borrow (a < b).
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
`ifdef ALU_ARB_FLAGS_EN
    output logic              carry_o,
`endif
    output logic [DATA_W-1:0] result_o
);

`ifdef ALU_ARB_FLAGS_EN
    logic [DATA_W:0] sum_w;
    assign sum_w = {1'b0, a_i} + {1'b0, b_i};

    // Result and flag selection by opcode
    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum_w[DATA_W-1:0];
                carry_o  = sum_w[DATA_W];
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                carry_o  = (a_i < b_i);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            default: result_o = '0;
        endcase
    end
`else
    // Result selection by opcode
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            default: result_o = '0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU.
// IDLE grants and captures, EXEC computes and registers, RESP holds the
// result until the consumer takes it. Optional flags: ALU_ARB_FLAGS_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic              last_q;          // requester served most recently
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              id_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_id_q;

    logic              accept_w;
    logic              grant_w;
    logic [DATA_W-1:0] alu_res_w;

`ifdef ALU_ARB_FLAGS_EN
    logic              alu_carry_w;
    logic              rsp_zero_q, rsp_carry_q;
`endif

    alu_core #(.DATA_W(DATA_W)) u_core (
        .op_i     (alu_op_e'(op_q)),
        .a_i      (a_q),
        .b_i      (b_q),
`ifdef ALU_ARB_FLAGS_EN
        .carry_o  (alu_carry_w),
`endif
        .result_o (alu_res_w)
    );

    // Next state, grant and ready generation; ready only ever in IDLE
    always_comb begin
        state_d        = state_q;
        accept_w       = 1'b0;
        grant_w        = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    accept_w = 1'b1;
                    // on contention serve whoever was not served last
                    grant_w  = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
                    bus.req0_ready = ~grant_w;
                    bus.req1_ready = grant_w;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == ST_RESP && bus.rsp_ready)
                last_q <= rsp_id_q;
        end
    end

    // Operand capture on accept; operands are not re-sampled afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (accept_w) begin
            op_q <= grant_w ? bus.req1_op : bus.req0_op;
            a_q  <= grant_w ? bus.req1_a  : bus.req0_a;
            b_q  <= grant_w ? bus.req1_b  : bus.req0_b;
            id_q <= grant_w;
        end
    end

    // Result registers loaded in EXEC, held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_data_q <= alu_res_w;
            rsp_id_q   <= id_q;
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    // Flag registers loaded alongside the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_zero_q  <= (alu_res_w == '0);
            rsp_carry_q <= alu_carry_w;
        end
    end
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_carry = rsp_carry_q;
`endif

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single/contended requests
// plus hand-written back-pressure, reset-in-flight, idle and streaming runs.
// Flag checks compile in with ALU_ARB_FLAGS_EN.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(32), .OP_W(2)) bus ();

    alu_arbiter #(.DATA_W(32), .OP_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v0, v1;
        logic [1:0]  op0, op1;
        logic [31:0] a0, b0, a1, b1;
        logic        exp_id;
        logic [31:0] exp_data;
        logic        exp_carry;
    } vec_t;

    vec_t tbl [8];

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready = 1'b0;
    endtask

    // Present one vector, check grant, EXEC, RESP contents, then retire it
    task automatic run_vec(input int i);
        vec_t v;
        v = tbl[i];
        @(negedge clk);
        bus.req0_valid = v.v0; bus.req0_op = v.op0; bus.req0_a = v.a0; bus.req0_b = v.b0;
        bus.req1_valid = v.v1; bus.req1_op = v.op1; bus.req1_a = v.a1; bus.req1_b = v.b1;
        bus.rsp_ready = 1'b0;
        #1;
        chk($sformatf("v%0d_ready0", i), bus.req0_ready, !v.exp_id);
        chk($sformatf("v%0d_ready1", i), bus.req1_ready, v.exp_id);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = 32'hDEAD_BEEF; bus.req1_a = 32'hDEAD_BEEF;  // must not be re-sampled
        chk($sformatf("v%0d_exec_busy", i), bus.busy, 1'b1);
        chk($sformatf("v%0d_exec_vld", i), bus.rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_rsp_vld", i), bus.rsp_valid, 1'b1);
        chk($sformatf("v%0d_rsp_id", i), bus.rsp_id, v.exp_id);
        chk($sformatf("v%0d_rsp_data", i), bus.rsp_data, v.exp_data);
`ifdef ALU_ARB_FLAGS_EN
        chk($sformatf("v%0d_carry", i), bus.rsp_carry, v.exp_carry);
        chk($sformatf("v%0d_zero", i), bus.rsp_zero, (v.exp_data == 32'h0));
`endif
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk($sformatf("v%0d_done_vld", i), bus.rsp_valid, 1'b0);
        chk($sformatf("v%0d_done_busy", i), bus.busy, 1'b0);
    endtask

    initial begin
        int got, cyc, last_cyc;

        //         v0 v1 op0    op1    a0            b0            a1            b1            id data          carry
        tbl[0] = '{1, 0, 2'b00, 2'b00, 32'd5,        32'd7,        32'd0,        32'd0,        0, 32'd12,       0};
        tbl[1] = '{0, 1, 2'b00, 2'b01, 32'd0,        32'd0,        32'd0,        32'd1,        1, 32'hFFFFFFFF, 1};
        tbl[2] = '{1, 1, 2'b10, 2'b11, 32'hF0F0,     32'h0FF0,     32'h1,        32'h2,        0, 32'h00F0,     0};
        tbl[3] = '{1, 1, 2'b10, 2'b11, 32'hF0F0,     32'h0FF0,     32'h1,        32'h2,        1, 32'h3,        0};
        tbl[4] = '{1, 0, 2'b01, 2'b00, 32'd5,        32'd5,        32'd0,        32'd0,        0, 32'h0,        0};
        tbl[5] = '{0, 1, 2'b00, 2'b00, 32'd0,        32'd0,        32'hFFFFFFFF, 32'd1,        1, 32'h0,        1};
        tbl[6] = '{1, 0, 2'b11, 2'b00, 32'hA0,       32'h05,       32'd0,        32'd0,        0, 32'hA5,       0};
        tbl[7] = '{0, 1, 2'b00, 2'b10, 32'd0,        32'd0,        32'hFFFF0000, 32'h12345678, 1, 32'h12340000, 0};

        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready0", bus.req0_ready, 1'b0);
        chk("rst_ready1", bus.req1_ready, 1'b0);
        chk("rst_vld", bus.rsp_valid, 1'b0);
        chk("rst_id", bus.rsp_id, 1'b0);
        chk("rst_data", bus.rsp_data, 32'h0);
        chk("rst_busy", bus.busy, 1'b0);
`ifdef ALU_ARB_FLAGS_EN
        chk("rst_zero", bus.rsp_zero, 1'b0);
        chk("rst_carry", bus.rsp_carry, 1'b0);
`endif
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Idle 10 cycles, rsp_ready high outside RESP must do nothing
        @(negedge clk); bus.rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_busy", bus.busy, 1'b0);
            chk("idle_vld", bus.rsp_valid, 1'b0);
            chk("idle_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        bus.rsp_ready = 1'b0;

        // Back-pressure: hold RESP 5 cycles
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;  // must not be granted
            #1;
            chk("bp_vld", bus.rsp_valid, 1'b1);
            chk("bp_data", bus.rsp_data, 32'd7);
            chk("bp_id", bus.rsp_id, 1'b0);
            chk("bp_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        chk("bp_done_vld", bus.rsp_valid, 1'b0);
        chk("bp_done_busy", bus.busy, 1'b0);

        // Reset in EXEC: last served is 0 here, so without reset req1 would win next
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_op = 2'b01; bus.req1_a = 32'd9; bus.req1_b = 32'd4;
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        chk("mid_in_exec", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", bus.rsp_valid, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_after_vld", bus.rsp_valid, 1'b0);
        chk("mid_after_busy", bus.busy, 1'b0);
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 32'd10; bus.req0_b = 32'd20;
        bus.req1_valid = 1'b1;
        #1;
        chk("mid_grant0", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(posedge clk); #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rsp_data", bus.rsp_data, 32'd30);
        chk("mid_rsp_id", bus.rsp_id, 1'b0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;

        // Streaming contention after a fresh reset
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b10; bus.req0_a = 32'hF0F0; bus.req0_b = 32'h0FF0;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_a = 32'h1;    bus.req1_b = 32'h2;
        bus.rsp_ready = 1'b1;
        got = 0; cyc = 0; last_cyc = 0;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            chk("cont_onehot", bus.req0_ready & bus.req1_ready, 1'b0);
            if (bus.rsp_valid) begin
                chk($sformatf("cont%0d_id", got), bus.rsp_id, got[0]);
                chk($sformatf("cont%0d_data", got), bus.rsp_data, got[0] ? 32'h3 : 32'h00F0);
                if (got > 0) chk($sformatf("cont%0d_gap", got), cyc - last_cyc, 3);
                last_cyc = cyc;
                got++;
            end
        end
        if (got < 4) chk("cont_timeout", got, 4);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        chk("cont_end_busy", bus.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
